// File: rtl/bresenham_line_stream.sv
// Streaming Bresenham line rasteriser: one command in, every pixel of the line out over valid/ready.
// Define LINE_CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H without changing the walk.
module bresenham_line_stream #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic signed [COORD_W+1:0] ERR_ZERO = '0;

  state_t                    state;
  logic [COORD_W-1:0]        cur_x, cur_y, end_x, end_y;
  logic signed [COORD_W:0]   dx, dy;
  logic                      sx, sy;
  logic signed [COORD_W+1:0] err;

  logic signed [COORD_W:0]   setup_dx, setup_dy;
  logic signed [COORD_W+2:0] e2, dx_e, dy_e;
  logic signed [COORD_W+1:0] err_dx, err_dy, err_nxt;
  logic                      step_x, step_y, at_end, on_screen, advance;

  function automatic logic signed [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                       input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return signed'({1'b0, d});
  endfunction

  function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] v, input logic up);
    return up ? (v + COORD_W'(1)) : (v - COORD_W'(1));
  endfunction

  assign setup_dx = abs_diff(end_x, cur_x);
  assign setup_dy = -abs_diff(end_y, cur_y);

  // Both axis decisions use the same doubled error term
  assign e2      = {err, 1'b0};
  assign dx_e    = {{2{dx[COORD_W]}}, dx};
  assign dy_e    = {{2{dy[COORD_W]}}, dy};
  assign err_dx  = {dx[COORD_W], dx};
  assign err_dy  = {dy[COORD_W], dy};
  assign step_x  = (e2 >= dy_e);
  assign step_y  = (e2 <= dx_e);
  assign err_nxt = err + (step_x ? err_dy : ERR_ZERO) + (step_y ? err_dx : ERR_ZERO);
  assign at_end  = (cur_x == end_x) && (cur_y == end_y);

`ifdef LINE_CLIP_EN
  assign on_screen = (int'(cur_x) < SCREEN_W) && (int'(cur_y) < SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif

  // Off-screen points are walked past at one step per cycle, independent of pix_ready
  assign advance   = (state == DRAW) && (pix_ready || !on_screen);

  assign busy      = (state != IDLE);
  assign pix_valid = (state == DRAW) && on_screen;
  assign pix_last  = pix_valid && at_end;
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;
  assign done      = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      end_x <= '0;
      end_y <= '0;
      dx    <= '0;
      dy    <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      err   <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_x <= x0;
            cur_y <= y0;
            end_x <= x1;
            end_y <= y1;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx    <= setup_dx;
          dy    <= setup_dy;
          sx    <= (end_x > cur_x);
          sy    <= (end_y > cur_y);
          err   <= {setup_dx[COORD_W], setup_dx} + {setup_dy[COORD_W], setup_dy};
          state <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              state <= DONE;
            end else begin
              if (step_x) cur_x <= step(cur_x, sx);
              if (step_y) cur_y <= step(cur_y, sy);
              err <= err_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_line_stream.sv
// Scoreboard bench for bresenham_line_stream: directed lines with hand-computed pixel lists,
// pixel cycle offsets and done timing; a negedge monitor pops and compares.
module tb_bresenham_line_stream;
  localparam int W = 10;

  logic         Clk = 1'b0;
  logic         Reset, start, abort, pix_ready;
  logic [W-1:0] x0, y0, x1, y1;
  logic         busy, pix_valid, pix_last, done;
  logic [W-1:0] pix_x, pix_y;

  typedef struct {
    int x;
    int y;
    bit last;
    int off;
  } pix_t;

  pix_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   line_t0 = 0;
  int   exp_done = -1;
  int   done_cnt = 0;

  bresenham_line_stream #(.COORD_W(W), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pe(input int x, input int y, input bit last, input int off);
    pix_t e;
    e.x = x; e.y = y; e.last = last; e.off = off;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every accepted pixel and checks done timing
  initial begin
    pix_t e;
    bit   stall_prev;
    int   hx, hy, hl;
    stall_prev = 1'b0;
    hx = 0; hy = 0; hl = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (stall_prev && pix_valid) begin
          chk("hold_x", int'(pix_x), hx);
          chk("hold_y", int'(pix_y), hy);
          chk("hold_last", int'(pix_last), hl);
        end
        stall_prev = pix_valid && !pix_ready;
        hx = int'(pix_x); hy = int'(pix_y); hl = int'(pix_last);
        if (pix_valid && pix_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pix", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("pix_x", int'(pix_x), e.x);
            chk("pix_y", int'(pix_y), e.y);
            chk("pix_last", int'(pix_last), int'(e.last));
            if (e.off >= 0) chk("pix_cycle", cyc - line_t0, e.off);
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_cycle", cyc, exp_done);
        end
      end
    end
  end

  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int doff);
    x0 = ax0[W-1:0]; y0 = ay0[W-1:0]; x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
    start    = 1'b1;
    line_t0  = cyc;
    exp_done = (doff < 0) ? -1 : cyc + doff;
  endtask

  task automatic wait_line(input bit tog);
    int d0;
    int g;
    d0 = done_cnt;
    g  = 0;
    @(posedge Clk); #1;
    start = 1'b0;
    x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
    pix_ready = tog ? ((cyc - line_t0) % 2 == 0) : 1'b1;
    @(negedge Clk);
    chk("setup_busy", int'(busy), 1);
    chk("setup_valid", int'(pix_valid), 0);
    while (done_cnt == d0 && g < 300) begin
      @(posedge Clk); #1;
      pix_ready = tog ? ((cyc - line_t0) % 2 == 0) : 1'b1;
      g++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    pix_ready = 1'b1;
    @(negedge Clk);
    chk("idle_busy", int'(busy), 0);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_line(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int doff, input bit tog);
    @(posedge Clk); #1;
    start_line(ax0, ay0, ax1, ay1, doff);
    wait_line(tog);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    x0 = 10'd3; y0 = 10'd3; x1 = 10'd7; y1 = 10'd7;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), 0);
    chk("rst_last", int'(pix_last), 0);
    chk("rst_done", int'(done), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Horizontal (0,0)->(5,0)
    for (int i = 0; i <= 5; i++) pe(i, 0, i == 5, 2 + i);
    do_line(0, 0, 5, 0, 8, 1'b0);

    // Steep reverse (3,7)->(1,0)
    pe(3, 7, 0, 2); pe(3, 6, 0, 3); pe(2, 5, 0, 4); pe(2, 4, 0, 5);
    pe(2, 3, 0, 6); pe(2, 2, 0, 7); pe(1, 1, 0, 8); pe(1, 0, 1, 9);
    do_line(3, 7, 1, 0, 10, 1'b0);

    // (0,0)->(4,2) with ready=1, then with ready toggling
    pe(0, 0, 0, 2); pe(1, 1, 0, 3); pe(2, 1, 0, 4); pe(3, 2, 0, 5); pe(4, 2, 1, 6);
    do_line(0, 0, 4, 2, 7, 1'b0);
    pe(0, 0, 0, 2); pe(1, 1, 0, 4); pe(2, 1, 0, 6); pe(3, 2, 0, 8); pe(4, 2, 1, 10);
    do_line(0, 0, 4, 2, 11, 1'b1);

    // Single point
    pe(4, 4, 1, 2);
    do_line(4, 4, 4, 4, 3, 1'b0);

    // Abort on the third pixel of (0,0)->(9,9), restart the following cycle
    @(posedge Clk); #1;
    pe(0, 0, 0, 2); pe(1, 1, 0, 3); pe(2, 2, 0, 4);
    start_line(0, 0, 9, 9, -1);
    @(posedge Clk); #1;
    start = 1'b0;
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd0; y1 = 10'd0;
    repeat (2) begin
      @(posedge Clk); #1;
    end
    @(posedge Clk); #1;
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    chk("abort_sb_empty", sb.size(), 0);
    pe(4, 4, 1, 2);
    start_line(4, 4, 4, 4, 3);
    @(negedge Clk);
    chk("abort_valid", int'(pix_valid), 0);
    chk("abort_busy", int'(busy), 0);
    wait_line(1'b0);

    // Line crossing x=640: clipped when LINE_CLIP_EN is defined
`ifdef LINE_CLIP_EN
    for (int i = 630; i <= 639; i++) pe(i, 10, 0, 2 + i - 630);
`else
    for (int i = 630; i <= 650; i++) pe(i, 10, i == 650, 2 + i - 630);
`endif
    do_line(630, 10, 650, 10, 23, 1'b0);

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
